// File: rtl/opsum_quant_packer_if.sv
// opsum_quant_packer_if: groups the upstream opsum stream (from the PE array)
// and the downstream GLB write stream into one bundle.
//   master: the environment side (drives opsums, accepts GLB words)
//   slave : the packer side
interface opsum_quant_packer_if #(
  parameter int DATA_SIZE = 32
);
  logic                 opsum_valid;
  logic                 opsum_ready;
  logic [DATA_SIZE-1:0] opsum_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_data;

  modport master (
    output opsum_valid, opsum_data, out_ready,
    input  opsum_ready, out_valid, out_data
  );

  modport slave (
    input  opsum_valid, opsum_data, out_ready,
    output opsum_ready, out_valid, out_data
  );
endinterface

// File: rtl/opsum_quant_packer.sv
// opsum_quant_packer: post-processing stage between the PE array opsum output
// and the GLB write port. Quant mode requantizes each 32-bit opsum to int8
// (round, arithmetic shift, optional ReLU, zero point, clamp) and packs four
// bytes per GLB word, first byte in bits [7:0]. Bypass mode forwards raw psums.
// Pipeline: S1 (byte or raw word) -> PACK (4 bytes + index) -> OUT.
// Optional macro OPSUM_QUANT_SAT_STATS_EN builds the clamp-event counter
// behind sat_cnt; without it sat_cnt is tied to zero.
module opsum_quant_packer #(
  parameter int DATA_SIZE  = 32,
  parameter int SHIFT_BITS = 5,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic                  cfg_bypass,
  input  logic                  cfg_relu,
  input  logic [SHIFT_BITS-1:0] cfg_shift,
  input  logic [7:0]            cfg_zp,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   sat_cnt,
  opsum_quant_packer_if.slave   bus
);

  // Quant arithmetic width: two guard bits above the opsum so the rounding
  // add and the zero-point add never wrap.
  localparam int QW = DATA_SIZE + 2;
  localparam logic signed [QW-1:0] Q_MAX = 127;
  localparam logic signed [QW-1:0] Q_MIN = -128;

  // Configuration registers
  logic                  bypass_q, bypass_d;
  logic                  relu_q, relu_d;
  logic [SHIFT_BITS-1:0] shift_q, shift_d;
  logic [7:0]            zp_q, zp_d;

  // Pipeline registers
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_SIZE-1:0]  s1_data_q, s1_data_d;
  logic [DATA_SIZE-1:0]  pack_q, pack_d;
  logic [1:0]            idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0]  out_data_q, out_data_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  flush_done_q, flush_done_d;

  // Handshake and quant datapath
  logic                  out_free;
  logic                  s1_moves;
  logic                  opsum_ready;
  logic                  accept;
  logic                  cfg_take;
  logic signed [QW-1:0]  q_x, q_rnd, q_sum, q_r, q_v;
  logic [7:0]            q_byte;

  assign busy     = s1_valid_q || (idx_q != 2'd0) || out_valid_q || flush_pend_q;
  assign cfg_take = cfg_load && !busy;

  // Requantize the incoming opsum: round half up, shift, ReLU, zero point, clamp.
  always_comb begin
    q_x   = $signed({{2{bus.opsum_data[DATA_SIZE-1]}}, bus.opsum_data});
    q_rnd = '0;
    if (shift_q != '0) q_rnd = QW'(1) << (shift_q - 1'b1);
    q_sum = q_x + q_rnd;
    q_r   = q_sum >>> shift_q;
    if (relu_q && q_r[QW-1]) q_r = '0;
    q_v   = q_r + $signed({{(QW-8){zp_q[7]}}, zp_q});
    if (q_v > Q_MAX)      q_byte = 8'h7F;
    else if (q_v < Q_MIN) q_byte = 8'h80;
    else                  q_byte = q_v[7:0];
  end

  // Next-state for the pipeline, packing index, flush sequencing and config.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    bypass_d     = bypass_q;
    relu_d       = relu_q;
    shift_d      = shift_q;
    zp_d         = zp_q;
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    pack_d       = pack_q;
    idx_d        = idx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;

    out_free = !out_valid_q || bus.out_ready;
    // In quant mode only the 4th byte needs room in OUT; bytes 1-3 always fit PACK.
    if (bypass_q) s1_moves = s1_valid_q && out_free;
    else          s1_moves = s1_valid_q && ((idx_q != 2'd3) || out_free);
    opsum_ready = !rst && !flush_pend_q && (!s1_valid_q || s1_moves);
    accept      = bus.opsum_valid && opsum_ready;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (s1_moves) begin
      if (bypass_q) begin
        out_valid_d = 1'b1;
        out_data_d  = s1_data_q;
      end else if (idx_q == 2'd3) begin
        out_valid_d = 1'b1;
        out_data_d  = {s1_data_q[7:0], pack_q[23:0]};
        pack_d      = '0;
        idx_d       = 2'd0;
      end else begin
        pack_d[{idx_q, 3'b000} +: 8] = s1_data_q[7:0];
        idx_d                        = idx_q + 2'd1;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = bypass_q ? bus.opsum_data : {{(DATA_SIZE-8){1'b0}}, q_byte};
    end else if (s1_moves) begin
      s1_valid_d = 1'b0;
    end

    // Flush waits for S1 to drain; PACK keeps unfilled bytes at zero, so a
    // partial word goes out as-is.
    if (flush_pend_q) begin
      if (!s1_valid_q) begin
        if (idx_q == 2'd0) begin
          flush_pend_d = 1'b0;
          flush_done_d = 1'b1;
        end else if (out_free) begin
          out_valid_d  = 1'b1;
          out_data_d   = pack_q;
          pack_d       = '0;
          idx_d        = 2'd0;
          flush_pend_d = 1'b0;
          flush_done_d = 1'b1;
        end
      end
    end else if (flush) begin
      flush_pend_d = 1'b1;
    end

    if (cfg_take) begin
      bypass_d = cfg_bypass;
      relu_d   = cfg_relu;
      shift_d  = cfg_shift;
      zp_d     = cfg_zp;
    end
  end

  // State registers; reset discards all in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q     <= 1'b0;
      relu_q       <= 1'b0;
      shift_q      <= '0;
      zp_q         <= '0;
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      pack_q       <= '0;
      idx_q        <= 2'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking only, so every register samples pre-edge values.
      bypass_q     <= bypass_d;
      relu_q       <= relu_d;
      shift_q      <= shift_d;
      zp_q         <= zp_d;
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      pack_q       <= pack_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.opsum_ready = opsum_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign flush_done      = flush_done_q;

`ifdef OPSUM_QUANT_SAT_STATS_EN
  logic                sat_cnt_q, sat_cnt_unused;
  logic [CNT_BITS-1:0] sat_q, sat_d;
  logic                q_sat;

  assign sat_cnt_q      = 1'b0;
  assign sat_cnt_unused = sat_cnt_q;

  // Count clamped quant results; sticks at all-ones, cleared by a taken cfg_load.
  always_comb begin
    q_sat = (q_v > Q_MAX) || (q_v < Q_MIN);
    sat_d = sat_q;
    if (cfg_take) sat_d = '0;
    else if (accept && !bypass_q && q_sat && (sat_q != '1)) sat_d = sat_q + 1'b1;
  end

  // Saturation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= '0;
    else     sat_q <= sat_d;
  end

  assign sat_cnt = sat_q;
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_opsum_quant_packer.sv
// tb_opsum_quant_packer: directed, table-driven bench for opsum_quant_packer.
// A vector table covers single-word transactions (bypass and quant); hand
// sequences cover flush, backpressure, config-while-busy and mid-stream reset.
module tb_opsum_quant_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_load = 1'b0;
  logic        cfg_bypass = 1'b0;
  logic        cfg_relu = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic [7:0]  cfg_zp = '0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        busy;
  logic [15:0] sat_cnt;

  opsum_quant_packer_if #(.DATA_SIZE(32)) bus ();

  opsum_quant_packer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_bypass (cfg_bypass),
    .cfg_relu   (cfg_relu),
    .cfg_shift  (cfg_shift),
    .cfg_zp     (cfg_zp),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy),
    .sat_cnt    (sat_cnt),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] out_q[$];
  int          out_cyc[$];
  int          acc_cyc[$];
  int          fd_cnt, fd_ov, stall_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe transfers between edges, where all signals are settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.opsum_valid && bus.opsum_ready) acc_cyc.push_back(cyc);
      if (bus.opsum_valid && !bus.opsum_ready) stall_seen++;
      if (bus.out_valid && bus.out_ready) begin
        out_q.push_back(bus.out_data);
        out_cyc.push_back(cyc);
      end
      if (flush_done) begin
        fd_cnt++;
        if (bus.out_valid) fd_ov++;
      end
    end
  end

  typedef struct {
    logic             bypass;
    logic             relu;
    logic [4:0]       shift;
    logic [7:0]       zp;
    int               n;
    logic [3:0][31:0] x;
    logic [31:0]      exp;
    int               sat;
  } vec_t;

  function automatic vec_t mk(input logic b, input logic r, input logic [4:0] s,
                              input logic [7:0] z, input int n,
                              input logic [31:0] x0, input logic [31:0] x1,
                              input logic [31:0] x2, input logic [31:0] x3,
                              input logic [31:0] e, input int sat);
    vec_t v;
    v.bypass = b; v.relu = r; v.shift = s; v.zp = z; v.n = n;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.exp = e; v.sat = sat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    out_q.delete();
    out_cyc.delete();
    acc_cyc.delete();
    fd_cnt = 0;
    fd_ov = 0;
    stall_seen = 0;
  endtask

  // All tasks start and end #1 after a rising edge.
  task automatic send(input logic [31:0] x);
    bus.opsum_valid = 1'b1;
    bus.opsum_data  = x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.opsum_ready) break;
    end
    if (!bus.opsum_ready) check("send_ready_timeout", {31'b0, bus.opsum_ready}, 32'd1);
    @(posedge clk); #1;
    bus.opsum_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic b, input logic r, input logic [4:0] s, input logic [7:0] z);
    cfg_bypass = b; cfg_relu = r; cfg_shift = s; cfg_zp = z;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_words(input int n, input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_q.size() >= n) break;
    end
    check(name, out_q.size(), n);
    @(posedge clk); #1;
  endtask

  vec_t        vec[7];
  logic [31:0] held;
  logic        held_valid;
  int          unstable;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opsum_valid = 1'b0;
    bus.opsum_data  = '0;
    bus.out_ready   = 1'b1;
    clear_mon();

    vec[0] = mk(1, 0, 5'd0,  8'h00, 1, 32'h12345678, 0, 0, 0, 32'h12345678, 0);
    vec[1] = mk(1, 0, 5'd0,  8'h00, 1, 32'hFFFFFFF0, 0, 0, 0, 32'hFFFFFFF0, 0);
    vec[2] = mk(0, 0, 5'd4,  8'h00, 4, 32'd32, -32'sd24, 32'd2047, -32'sd5000, 32'h807FFF02, 2);
    vec[3] = mk(0, 0, 5'd0,  8'h00, 4, 32'd1, -32'sd1, 32'd127, -32'sd128, 32'h807FFF01, 0);
    vec[4] = mk(0, 1, 5'd2,  8'hFD, 4, -32'sd100, 32'd10, 32'd6, 32'd400, 32'h61FF00FD, 0);
    vec[5] = mk(0, 0, 5'd31, 8'h05, 4, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h40000000, 32'h06050406, 0);
    vec[6] = mk(0, 0, 5'd0,  8'h7F, 4, 32'd1, -32'sd200, 32'd0, -32'sd255, 32'h807FB77F, 1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_opsum_ready", {31'b0, bus.opsum_ready}, 32'd0);
    check("rst_out_valid",   {31'b0, bus.out_valid},   32'd0);
    check("rst_out_data",    bus.out_data,             32'd0);
    check("rst_flush_done",  {31'b0, flush_done},      32'd0);
    check("rst_busy",        {31'b0, busy},            32'd0);
    check("rst_sat_cnt",     {16'b0, sat_cnt},         32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_opsum_ready", {31'b0, bus.opsum_ready}, 32'd1);
    @(posedge clk); #1;

    // Table-driven single-word transactions
    for (int e = 0; e < 7; e++) begin
      wait_idle();
      load_cfg(vec[e].bypass, vec[e].relu, vec[e].shift, vec[e].zp);
      clear_mon();
      for (int k = 0; k < vec[e].n; k++) send(vec[e].x[k]);
      wait_words(1, $sformatf("vec%0d_count", e));
      if (out_q.size() > 0 && acc_cyc.size() > 0) begin
        check($sformatf("vec%0d_data", e), out_q[0], vec[e].exp);
        check($sformatf("vec%0d_latency", e), out_cyc[0] - acc_cyc[acc_cyc.size()-1], 32'd2);
      end
`ifdef OPSUM_QUANT_SAT_STATS_EN
      check($sformatf("vec%0d_sat_cnt", e), {16'b0, sat_cnt}, vec[e].sat);
`else
      check($sformatf("vec%0d_sat_cnt", e), {16'b0, sat_cnt}, 32'd0);
`endif
    end

    // Flush of a 3-byte word, 3rd opsum accepted together with the flush pulse
    wait_idle();
    load_cfg(0, 1, 5'd0, 8'd10);
    clear_mon();
    send(-32'sd7);
    send(32'd5);
    bus.opsum_valid = 1'b1;
    bus.opsum_data  = 32'd200;
    flush = 1'b1;
    @(negedge clk);
    check("flush_same_cycle_ready", {31'b0, bus.opsum_ready}, 32'd1);
    @(posedge clk); #1;
    bus.opsum_valid = 1'b0;
    flush = 1'b0;
    wait_words(1, "flush_word_count");
    if (out_q.size() > 0) check("flush_word_data", out_q[0], 32'h007F0F0A);
    wait_idle();
    check("flush_done_pulses", fd_cnt, 32'd1);
    check("flush_done_with_out_valid", fd_ov, 32'd1);
    // Index back at 0: the next 4 bytes start at bits [7:0]
    clear_mon();
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    wait_words(1, "post_flush_count");
    if (out_q.size() > 0) check("post_flush_data", out_q[0], 32'h0E0D0C0B);

    // Flush with nothing packed: pulse only, no word
    wait_idle();
    clear_mon();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("empty_flush_done_pulses", fd_cnt, 32'd1);
    check("empty_flush_no_word", out_q.size(), 32'd0);

    // Backpressure: 12 opsums, out_ready low for a stretch mid-stream
    wait_idle();
    load_cfg(0, 0, 5'd0, 8'd0);
    clear_mon();
    held_valid = 1'b0;
    unstable = 0;
    fork
      begin
        for (int k = 0; k < 12; k++) send(k);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (bus.out_valid) begin
            if (held_valid && bus.out_data !== held) unstable++;
            held = bus.out_data;
            held_valid = 1'b1;
          end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_words(3, "bp_word_count");
    if (out_q.size() >= 3) begin
      check("bp_word0", out_q[0], 32'h03020100);
      check("bp_word1", out_q[1], 32'h07060504);
      check("bp_word2", out_q[2], 32'h0B0A0908);
    end
    check("bp_held_word_seen", {31'b0, held_valid}, 32'd1);
    check("bp_out_data_stable", unstable, 32'd0);
    check("bp_opsum_ready_dropped", {31'b0, (stall_seen > 0)}, 32'd1);

    // cfg_load while busy is ignored; retried when idle it takes effect
    wait_idle();
    load_cfg(0, 0, 5'd0, 8'd0);
    clear_mon();
    send(32'd16);
    send(32'd32);
    check("cfg_busy_precondition", {31'b0, busy}, 32'd1);
    load_cfg(0, 0, 5'd8, 8'd0);
    send(32'd48);
    send(32'd64);
    wait_words(1, "cfg_busy_count");
    if (out_q.size() > 0) check("cfg_busy_ignored", out_q[0], 32'h40302010);
    wait_idle();
    load_cfg(0, 0, 5'd8, 8'd0);
    clear_mon();
    send(32'd256); send(32'd512); send(32'd384); send(32'd127);
    wait_words(1, "cfg_idle_count");
    if (out_q.size() > 0) check("cfg_idle_applied", out_q[0], 32'h00020201);

    // Reset mid-stream with a word held in OUT and bytes in flight
    wait_idle();
    load_cfg(0, 0, 5'd0, 8'd0);
    clear_mon();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(32'h11 + k);
    check("mid_rst_out_valid_before", {31'b0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_out_data",  bus.out_data,           32'd0);
    check("mid_rst_busy",      {31'b0, busy},          32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    clear_mon();
    send(32'd1); send(32'd2); send(32'd3); send(32'd4);
    wait_words(1, "after_rst_count");
    if (out_q.size() > 0) check("after_rst_data", out_q[0], 32'h04030201);
    repeat (4) @(posedge clk);
    #1;
    check("after_rst_single_word", out_q.size(), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
